// File: rtl/dmg_pkg.sv
// Shared definitions for the damage_apply slice: default geometry and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmg_pkg;

    localparam int              N_ENT_DEF   = 16;
    localparam int              HP_W_DEF    = 8;
    localparam int              DMG_W_DEF   = 12;
    localparam logic [7:0]      HP_INIT_DEF = 8'd100;

    // One-hot round states; bit 2 doubles as the Done output.
    localparam logic [2:0]      ST_INITIAL_OH = 3'b001;
    localparam logic [2:0]      ST_APPLY_OH   = 3'b010;
    localparam logic [2:0]      ST_DONE_OH    = 3'b100;

    typedef enum logic [2:0] {
        ST_INITIAL = ST_INITIAL_OH,
        ST_APPLY   = ST_APPLY_OH,
        ST_DONE    = ST_DONE_OH
    } state_e;

endpackage

// File: rtl/hp_bank.sv
// Per-entity HP register file with one write port, two read ports and a live-entity mask.
// Latency: writes land on the next clk edge; reads and alive_mask are combinational from the bank.
// Backpressure: none; a write is taken whenever wr_en is high.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (bank reloads HP_INIT)
//   wr_en/idx/val     single write port (caller muxes load path vs apply path)
//   rd_a_idx/val      read port used by the damage walk
//   rd_b_idx/val      read port used for display
//   alive_mask        bit i set while hp[i] != 0
module hp_bank
    import dmg_pkg::*;
#(
    parameter int              N_ENT   = N_ENT_DEF,
    parameter int              HP_W    = HP_W_DEF,
    parameter logic [HP_W-1:0] HP_INIT = HP_W'(HP_INIT_DEF),
    parameter int              IDX_W   = $clog2(N_ENT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [HP_W-1:0]   wr_val,
    input  logic [IDX_W-1:0]  rd_a_idx,
    output logic [HP_W-1:0]   rd_a_val,
    input  logic [IDX_W-1:0]  rd_b_idx,
    output logic [HP_W-1:0]   rd_b_val,
    output logic [N_ENT-1:0]  alive_mask
);

    logic [HP_W-1:0] hp_q [N_ENT];
    logic [HP_W-1:0] hp_d [N_ENT];

    always_comb begin
        for (int i = 0; i < N_ENT; i++) begin
            hp_d[i] = hp_q[i];
        end
        if (wr_en) begin
            hp_d[wr_idx] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                hp_q[i] <= HP_INIT;
            end
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                hp_q[i] <= hp_d[i];
            end
        end
    end

    assign rd_a_val = hp_q[rd_a_idx];
    assign rd_b_val = hp_q[rd_b_idx];

    always_comb begin
        alive_mask = '0;
        for (int i = 0; i < N_ENT; i++) begin
            alive_mask[i] = (hp_q[i] != '0);
        end
    end

endmodule

// File: rtl/damage_apply.sv
// Applies one round's summed damage to an HP bank, front-line first, skipping dead entities.
// Latency: Done rises 1..N_ENT cycles after the edge that accepts Start (one cycle per visited entity).
// Backpressure: Start is taken only in INITIAL; the result is held in DONE until Ack.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (aborts round, restores HP)
//   Start, damageIn          begin a round with this damage total
//   Ack                      release from DONE back to INITIAL
//   hpLoadEn/Idx/Val         HP bank write, honoured only in INITIAL
//   hpRdIdx, hpRdVal         combinational display read
//   aliveMask, allDead       combinational liveness of the bank
//   leftover                 registered damage not absorbed by the round
//   Done                     high while the round result is being presented
// Build option: define OVERKILL_SPILL_EN to let excess damage carry on to the next living entity.
module damage_apply
    import dmg_pkg::*;
#(
    parameter int              N_ENT   = N_ENT_DEF,
    parameter int              HP_W    = HP_W_DEF,
    parameter int              DMG_W   = DMG_W_DEF,
    parameter logic [HP_W-1:0] HP_INIT = HP_W'(HP_INIT_DEF),
    parameter int              IDX_W   = $clog2(N_ENT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic              Ack,
    input  logic [DMG_W-1:0]  damageIn,
    input  logic              hpLoadEn,
    input  logic [IDX_W-1:0]  hpLoadIdx,
    input  logic [HP_W-1:0]   hpLoadVal,
    input  logic [IDX_W-1:0]  hpRdIdx,
    output logic [HP_W-1:0]   hpRdVal,
    output logic [N_ENT-1:0]  aliveMask,
    output logic              allDead,
    output logic [DMG_W-1:0]  leftover,
    output logic              Done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENT - 1);

    state_e             state_q, state_d;
    logic [DMG_W-1:0]   rem_q, rem_d;
    logic [DMG_W-1:0]   leftover_q, leftover_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [HP_W-1:0]    wr_val;
    logic [HP_W-1:0]    cur_hp;
    logic [DMG_W-1:0]   cur_hp_ext;
    logic               advance;

    hp_bank #(
        .N_ENT   (N_ENT),
        .HP_W    (HP_W),
        .HP_INIT (HP_INIT),
        .IDX_W   (IDX_W)
    ) u_hp_bank (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_val     (wr_val),
        .rd_a_idx   (idx_q),
        .rd_a_val   (cur_hp),
        .rd_b_idx   (hpRdIdx),
        .rd_b_val   (hpRdVal),
        .alive_mask (aliveMask)
    );

    assign cur_hp_ext = {{(DMG_W - HP_W){1'b0}}, cur_hp};

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        leftover_d = leftover_q;
        wr_en      = 1'b0;
        wr_idx     = hpLoadIdx;
        wr_val     = hpLoadVal;
        advance    = 1'b0;

        unique case (state_q)
            ST_INITIAL: begin
                // A load in the Start cycle lands before the first APPLY read.
                wr_en = hpLoadEn;
                if (Start) begin
                    rem_d   = damageIn;
                    idx_d   = '0;
                    state_d = ST_APPLY;
                end
            end

            ST_APPLY: begin
                wr_idx = idx_q;
                wr_val = '0;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (cur_hp == '0) begin
                    advance = 1'b1;
                end else if (rem_q >= cur_hp_ext) begin
                    // Lethal hit: entity absorbs exactly its HP.
                    rem_d = rem_q - cur_hp_ext;
                    wr_en = 1'b1;
`ifdef OVERKILL_SPILL_EN
                    advance = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    // Non-lethal hit: rem < hp, so the low bits hold the whole remainder.
                    wr_en   = 1'b1;
                    wr_val  = cur_hp - rem_q[HP_W-1:0];
                    rem_d   = '0;
                    state_d = ST_DONE;
                end

                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end

                leftover_d = rem_d;
            end

            ST_DONE: begin
                if (Ack) begin
                    state_d = ST_INITIAL;
                end
            end

            default: begin
                state_d = ST_INITIAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INITIAL;
            rem_q      <= '0;
            idx_q      <= '0;
            leftover_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            leftover_q <= leftover_d;
        end
    end

    assign Done     = state_q[2];
    assign leftover = leftover_q;
    assign allDead  = (aliveMask == '0);

endmodule
